pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and pipeline-sequencing controller for the five-stage pipeline. Drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Handles three cases:
- inserts a one-cycle bubble on load-use hazards;
- flushes the IF/ID and ID/EX registers on a taken branch resolved in EX;
- freezes the whole pipeline while data memory is busy.

It also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of each performance counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  IF/ID holds a real instruction (0 = bubble)
- id_rs_i  in  5  rs field of the instruction in IF/ID
- id_rt_i  in  5  rt field of the instruction in IF/ID
- id_uses_rt_i  in  1  that instruction reads rt as a source
- ex_mem_read_i  in  1  the instruction in ID/EX is a load
- ex_rt_i  in  5  destination register of that load
- branch_taken_i  in  1  branch in EX resolved taken this cycle
- mem_busy_i  in  1  data memory cannot complete this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID load enable
- idex_write_o  out  1  ID/EX load enable
- exmem_write_o  out  1  EX/MEM load enable
- memwb_write_o  out  1  MEM/WB load enable
- ifid_flush_o  out  1  clear IF/ID to zero (NOP); has priority over write
- idex_flush_o  out  1  clear ID/EX to zero (bubble); has priority over write
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 since reset
- flush_cnt_o  out  CNT_W  taken-branch flushes since reset

## Operation
- **Load-use hazard**, lu = all of:
  - id_valid_i
  - ex_mem_read_i
  - ex_rt_i != 0
  - (ex_rt_i == id_rs_i) or (id_uses_rt_i and ex_rt_i == id_rt_i)
- **FSM states:** RUN, LU_BUBBLE, MEM_WAIT.
- **Output priority:** freeze > branch flush > load-use > normal. Outputs are combinational from state and inputs.
- **Freeze** (mem_busy_i=1, any state):
  - all five write enables 0, both flushes 0;
  - next state MEM_WAIT.
- **Branch** (mem_busy_i=0, branch_taken_i=1):
  - all writes 1, ifid_flush_o=1, idex_flush_o=1;
  - flush_cnt increments;
  - next state RUN;
  - a coincident lu is discarded, because the dependent instruction is flushed.
- **Load-use** (mem_busy_i=0, branch_taken_i=0, lu=1, state != LU_BUBBLE):
  - pc_write_o=0, ifid_write_o=0, idex_flush_o=1;
  - idex_write_o, exmem_write_o, memwb_write_o stay 1;
  - next state LU_BUBBLE.
- **LU_BUBBLE:** lu detection is suppressed for this one cycle, since ID/EX holds the bubble. Otherwise behaves as RUN; next state RUN.
- **MEM_WAIT:**
  - stays in MEM_WAIT while mem_busy_i=1;
  - on the release cycle (mem_busy_i=0) it evaluates branch, lu and normal exactly as RUN, with lu not suppressed;
  - next state follows those rules.
- **Normal:** all writes 1, flushes 0, next state RUN.
- **Counters:**
  - stall_cnt increments on every cycle with pc_write_o=0;
  - flush_cnt increments on every branch-flush cycle;
  - both saturate at 2^CNT_W-1 and never wrap.

## Timing
- While rst_i=1: state RUN, counters 0, all write enables and flushes forced to 0. This is asynchronous: outputs drop immediately on reset assertion, including mid-stall or mid-freeze.
- First cycle after rst_i deasserts, with idle inputs: pc/ifid/idex/exmem/memwb writes = 1, flushes = 0, counters = 0.
- All control outputs are zero-latency (same cycle as the inputs). State and counters update at the next rising edge.
- A load-use stall costs exactly 1 cycle.
- A freeze lasts exactly as many cycles as mem_busy_i is high.
- branch_taken_i held during a freeze is acted on in the release cycle only, and counted once.

## Test plan
- **Reset:** assert rst_i mid-cycle during MEM_WAIT.
  - Required: all outputs 0 immediately.
  - After release, idle inputs: writes 1, stall_cnt_o=0, flush_cnt_o=0.
- **Load-use:** ex_mem_read_i=1, ex_rt_i=5, id_rs_i=5, id_valid_i=1 for 2 cycles.
  - Cycle 1: pc_write_o=0, ifid_write_o=0, idex_flush_o=1.
  - Cycle 2 (LU_BUBBLE): pc_write_o=1.
  - stall_cnt_o=1.
- **Register zero / unused rt:**
  - ex_rt_i=0 with id_rs_i=0 -> no stall;
  - ex_rt_i=7, id_rt_i=7, id_uses_rt_i=0 -> no stall.
- **Branch beats load-use:** branch_taken_i=1 and lu=1 in the same cycle.
  - Required: both flushes 1, pc_write_o=1, flush_cnt_o=1, stall_cnt_o unchanged.
- **Freeze:** mem_busy_i=1 for 3 cycles with branch_taken_i=1 throughout.
  - Required: all writes 0 for 3 cycles, then release cycle shows both flushes.
  - Result: stall_cnt_o=3, flush_cnt_o=1.
- **Saturation:** CNT_W=4, hold mem_busy_i=1 for 20 cycles.
  - Required: stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for a five-stage pipeline.
// Generates write-enable and flush controls for the PC and the four pipeline
// registers. It covers load-use bubbles, taken-branch flushes resolved in EX
// and full-pipeline freezes while data memory is busy. It also keeps
// saturating stall/flush counters for performance debug.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             lu_raw;
    logic             lu_hit;
    logic             branch_flush;

    // Raw load-use match: the load in EX writes a register the ID instruction
    // reads. Register zero never creates a dependency.
    assign lu_raw = id_valid_i && ex_mem_read_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // While the bubble sits in ID/EX the match is stale, so it is ignored.
    assign lu_hit = lu_raw && (state_reg != LU_BUBBLE);

    // Control outputs: freeze > branch flush > load-use > normal.
    // Reset forces every control low immediately.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        memwb_write_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        branch_flush  = 1'b0;
        state_next    = RUN;
        if (rst_i) begin
            state_next = RUN;
        end else if (mem_busy_i) begin
            state_next = MEM_WAIT;
        end else if (branch_taken_i) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_write_o  = 1'b1;
            exmem_write_o = 1'b1;
            memwb_write_o = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            branch_flush  = 1'b1;
            state_next    = RUN;
        end else if (lu_hit) begin
            // Hold PC and IF/ID, load a bubble into ID/EX, let the rest drain.
            idex_write_o  = 1'b1;
            exmem_write_o = 1'b1;
            memwb_write_o = 1'b1;
            idex_flush_o  = 1'b1;
            state_next    = LU_BUBBLE;
        end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_write_o  = 1'b1;
            exmem_write_o = 1'b1;
            memwb_write_o = 1'b1;
            state_next    = RUN;
        end
    end

    // State register and saturating performance counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= RUN;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (!pc_write_o && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (branch_flush && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic.
// The reference model works from the hazard rules directly. Two DUT copies
// share stimulus: one with 16-bit counters and one with 4-bit counters, so
// counter saturation is exercised.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_uses_rt_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rt_i;
    logic        branch_taken_i;
    logic        mem_busy_i;

    logic        pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_w, s_ifid_w, s_idex_w, s_exmem_w, s_memwb_w, s_ifid_f, s_idex_f;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int exp_stall;
    int exp_flush;
    bit bubble_last;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
        .branch_taken_i(branch_taken_i), .mem_busy_i(mem_busy_i),
        .pc_write_o(pc_w), .ifid_write_o(ifid_w), .idex_write_o(idex_w),
        .exmem_write_o(exmem_w), .memwb_write_o(memwb_w),
        .ifid_flush_o(ifid_f), .idex_flush_o(idex_f),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_mem_read_i(ex_mem_read_i), .ex_rt_i(ex_rt_i),
        .branch_taken_i(branch_taken_i), .mem_busy_i(mem_busy_i),
        .pc_write_o(s_pc_w), .ifid_write_o(s_ifid_w), .idex_write_o(s_idex_w),
        .exmem_write_o(s_exmem_w), .memwb_write_o(s_memwb_w),
        .ifid_flush_o(s_ifid_f), .idex_flush_o(s_idex_f),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] ctrl_main();
        return {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f};
    endfunction

    function automatic logic [6:0] ctrl_sat();
        return {s_pc_w, s_ifid_w, s_idex_w, s_exmem_w, s_memwb_w, s_ifid_f, s_idex_f};
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        id_valid_i     = 1'b0;
        id_rs_i        = 5'd0;
        id_rt_i        = 5'd0;
        id_uses_rt_i   = 1'b0;
        ex_mem_read_i  = 1'b0;
        ex_rt_i        = 5'd0;
        branch_taken_i = 1'b0;
        mem_busy_i     = 1'b0;
    endtask

    // Hold reset over two edges, release mid-cycle, end at posedge+1.
    task automatic do_reset();
        rst_i = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #4;
        rst_i       = 1'b0;
        exp_stall   = 0;
        exp_flush   = 0;
        bubble_last = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One pipeline cycle: drive, check zero-latency controls, clock, check counters.
    task automatic cycle(input string tag, input logic vld, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic mr,
                         input logic [4:0] ert, input logic br, input logic busy);
        bit         lu;
        bit         lu_stall;
        logic [6:0] exp_ctrl;
        id_valid_i     = vld;
        id_rs_i        = rs;
        id_rt_i        = rt;
        id_uses_rt_i   = urt;
        ex_mem_read_i  = mr;
        ex_rt_i        = ert;
        branch_taken_i = br;
        mem_busy_i     = busy;
        lu = vld && mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        lu_stall = 1'b0;
        if (busy)                     exp_ctrl = 7'b0000000;
        else if (br)                  exp_ctrl = 7'b1111111;
        else if (lu && !bubble_last) begin
            exp_ctrl = 7'b0011101;
            lu_stall = 1'b1;
        end else                      exp_ctrl = 7'b1111100;
        #1;
        check({tag, "_ctrl"}, 32'(ctrl_main()), 32'(exp_ctrl));
        check({tag, "_ctrl_sat"}, 32'(ctrl_sat()), 32'(exp_ctrl));
        @(posedge clk);
        if (!exp_ctrl[6]) exp_stall++;
        if (!busy && br)  exp_flush++;
        bubble_last = lu_stall;
        #1;
        check({tag, "_stall"}, 32'(stall_cnt), 32'(sat(exp_stall, 65535)));
        check({tag, "_flush"}, 32'(flush_cnt), 32'(sat(exp_flush, 65535)));
        check({tag, "_stall_sat"}, 32'(s_stall_cnt), 32'(sat(exp_stall, 15)));
        check({tag, "_flush_sat"}, 32'(s_flush_cnt), 32'(sat(exp_flush, 15)));
        $display("[%0t] %s ctrl=%b stall=%0d flush=%0d", $time, tag, exp_ctrl, stall_cnt, flush_cnt);
    endtask

    initial begin
        rst_i = 1'b1;
        set_idle();
        exp_stall   = 0;
        exp_flush   = 0;
        bubble_last = 1'b0;
        #1;
        check("rst_initial_ctrl", 32'(ctrl_main()), 32'h0);

        // Reset asserted mid-cycle while frozen in MEM_WAIT
        do_reset();
        cycle("frz_pre", 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("frz_pre", 0, 0, 0, 0, 0, 0, 1, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_ctrl", 32'(ctrl_main()), 32'h0);
        check("rst_async_stall", 32'(stall_cnt), 32'd0);
        do_reset();
        cycle("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_pc", 32'(pc_w), 32'd1);
        check("post_rst_stall", 32'(stall_cnt), 32'd0);
        check("post_rst_flush", 32'(flush_cnt), 32'd0);

        // Reset asserted mid-cycle during a load-use stall
        id_valid_i = 1'b1; id_rs_i = 5'd9; ex_mem_read_i = 1'b1; ex_rt_i = 5'd9;
        #1;
        check("lu_pre_rst_ctrl", 32'(ctrl_main()), 32'(7'b0011101));
        #2;
        rst_i = 1'b1;
        #1;
        check("lu_rst_ctrl", 32'(ctrl_main()), 32'h0);
        do_reset();

        // Load-use: two cycles with the same dependency
        cycle("lu1", 1, 5, 0, 0, 1, 5, 0, 0);
        cycle("lu2", 1, 5, 0, 0, 1, 5, 0, 0);
        check("lu_stall_total", 32'(stall_cnt), 32'd1);

        // Register zero and unused rt never stall; a used rt does
        cycle("rzero", 1, 0, 0, 0, 1, 0, 0, 0);
        cycle("rt_unused", 1, 3, 7, 0, 1, 7, 0, 0);
        check("nostall_total", 32'(stall_cnt), 32'd1);
        cycle("rt_used", 1, 3, 7, 1, 1, 7, 0, 0);
        check("rt_used_total", 32'(stall_cnt), 32'd2);

        // Branch beats a coincident load-use
        do_reset();
        cycle("br_lu", 1, 5, 0, 0, 1, 5, 1, 0);
        check("br_lu_flush", 32'(flush_cnt), 32'd1);
        check("br_lu_stall", 32'(stall_cnt), 32'd0);

        // Freeze for 3 cycles with a pending branch, then release
        do_reset();
        repeat (3) cycle("frz", 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("frz_rel", 0, 0, 0, 0, 0, 0, 1, 0);
        check("frz_stall", 32'(stall_cnt), 32'd3);
        check("frz_flush", 32'(flush_cnt), 32'd1);

        // Counter saturation on the 4-bit instance
        do_reset();
        repeat (20) cycle("sat", 0, 0, 0, 0, 0, 0, 0, 1);
        check("sat_stall4", 32'(s_stall_cnt), 32'd15);
        check("sat_stall16", 32'(stall_cnt), 32'd20);

        // Randomized traffic with small register indices to provoke hazards
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ((i % 400) == 399) do_reset();
            cycle("rnd",
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
